// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV64 controller: FSM states, opcode classes,
// opcode constants, ALUOp and trap-cause codes, and the bundled control-strobe struct.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_ILL = 3'd5
  } op_class_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       retire;
  } ctrl_t;

  // Only BEQ and BNE are supported; every other branch funct3 falls through.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class_dec.sv
// Combinational opcode classifier: maps Instruction[6:0] onto the controller's
// instruction classes, flagging anything unsupported as illegal.
module multicycle_ctrl_opcode_class_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILL;
    case (opcode)
      OP_R:    op_class = CLS_R;
      OP_I:    op_class = CLS_I;
      OP_LD:   op_class = CLS_LD;
      OP_ST:   op_class = CLS_ST;
      OP_BR:   op_class = CLS_BR;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) for the RV64 datapath, with a
// memory-wait watchdog, sticky trap reporting and a wrapping retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output state_e           state_dbg
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  op_class_e        class_q, class_d, dec_class;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  ctrl_t            ctrl_c, ctrl_o;
  logic             wait_expired;

  multicycle_ctrl_opcode_class_dec u_dec (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

  // Memory handshake: imem_req/MemRead/MemWrite stay high while waiting; the access
  // completes in the first cycle the matching ready is high. Readies are ignored elsewhere.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    wait_cnt_d   = '0;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    ctrl_c       = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.imem_req = 1'b1;
        if (imem_ready) begin
          ctrl_c.ir_write = 1'b1;
          state_d         = ST_DECODE;
        end else if (wait_expired) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_IMEM_TO;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        if (dec_class == CLS_ILL) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CLS_R: begin
            ctrl_c.alu_op = ALUOP_FUNCT;
            state_d       = ST_WB;
          end
          CLS_I: begin
            ctrl_c.alu_src = 1'b1;
            ctrl_c.alu_op  = ALUOP_FUNCT;
            state_d        = ST_WB;
          end
          CLS_LD, CLS_ST: begin
            ctrl_c.alu_src = 1'b1;
            ctrl_c.alu_op  = ALUOP_ADD;
            state_d        = ST_MEM;
          end
          CLS_BR: begin
            ctrl_c.alu_op   = ALUOP_SUB;
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = branch_taken(funct3, alu_zero);
            ctrl_c.retire   = 1'b1;
            state_d         = ST_FETCH;
          end
          default: begin
            state_d      = ST_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.mem_read  = (class_q == CLS_LD);
        ctrl_c.mem_write = (class_q == CLS_ST);
        if (dmem_ready) begin
          if (class_q == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.retire   = 1'b1;
            state_d         = ST_FETCH;
          end
        end else if (wait_expired) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_DMEM_TO;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = (class_q != CLS_LD);
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.retire     = 1'b1;
        state_d           = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
    retired_cnt_d = ctrl_c.retire ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      class_q       <= CLS_R;
      wait_cnt_q    <= '0;
      retired_cnt_q <= '0;
      trap_q        <= 1'b0;
      trap_cause_q  <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      class_q       <= class_d;
      wait_cnt_q    <= wait_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      trap_q        <= trap_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  // Strobes are forced low while reset is asserted, whatever the state register holds.
  assign ctrl_o = reset ? ctrl_c : '0;

  assign imem_req    = ctrl_o.imem_req;
  assign ir_write    = ctrl_o.ir_write;
  assign pc_write    = ctrl_o.pc_write;
  assign pc_src      = ctrl_o.pc_src;
  assign ALUSrc      = ctrl_o.alu_src;
  assign ALUOp       = ctrl_o.alu_op;
  assign MemRead     = ctrl_o.mem_read;
  assign MemWrite    = ctrl_o.mem_write;
  assign MemtoReg    = ctrl_o.mem_to_reg;
  assign RegWrite    = ctrl_o.reg_write;
  assign retire      = ctrl_o.retire;
  assign retired_cnt = retired_cnt_q;
  assign trap        = trap_q;
  assign trap_cause  = trap_cause_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction latency scoreboard, strobe checks,
// branch resolution, illegal-opcode and watchdog traps, reset recovery and counter wrap.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  localparam logic [6:0] T_R  = 7'b0110011;
  localparam logic [6:0] T_I  = 7'b0010011;
  localparam logic [6:0] T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011;
  localparam logic [6:0] T_BR = 7'b1100011;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [6:0]       opcode = 7'h33;
  logic [2:0]       funct3 = 3'b000;
  logic             alu_zero = 1'b0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, ir_write, pc_write, pc_src, ALUSrc;
  logic [1:0]       ALUOp;
  logic             MemRead, MemWrite, MemtoReg, RegWrite, retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             trap;
  logic [1:0]       trap_cause;
  state_e           state_dbg;
  logic [11:0]      strobes;

  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic [7:0]       exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .alu_zero    (alu_zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ALUSrc      (ALUSrc),
    .ALUOp       (ALUOp),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .state_dbg   (state_dbg)
  );

  assign strobes = {imem_req, ir_write, pc_write, pc_src, ALUSrc, ALUOp,
                    MemRead, MemWrite, MemtoReg, RegWrite, retire};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int base_lat(input logic [6:0] op);
    case (op)
      T_BR:    return 3;
      T_LD:    return 5;
      default: return 4;
    endcase
  endfunction

  // Leaves the bench just after the negedge of the first FETCH cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = T_R;
    #1 chk("rst_strobes_c1", strobes, 12'h000);
    @(negedge clk);
    #1 chk("rst_strobes_c2", strobes, 12'h000);
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("post_rst_strobes", strobes, 12'h800);
    chk("post_rst_cnt", retired_cnt, 0);
    chk("post_rst_trap", {trap, trap_cause}, 3'b000);
    cnt_model = '0;
    exp_q.delete();
  endtask

  // Runs one instruction from its first FETCH cycle; istall imem-low cycles, dstall dmem-low cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic zr,
                           input int istall, input int dstall);
    int  lat;
    int  mem_start;
    int  mem_cycles;
    bit  done;
    bit  is_mem;
    logic exp_taken;
    is_mem     = (op == T_LD) || (op == T_ST);
    lat        = base_lat(op) + istall + (is_mem ? dstall : 0);
    mem_start  = istall + 4;
    mem_cycles = 0;
    done       = 1'b0;
    exp_taken  = ((f3 == 3'b000) && zr) || ((f3 == 3'b001) && !zr);
    exp_q.push_back(8'(lat));
    for (int c = 1; c <= 60 && !done; c++) begin
      opcode = op; funct3 = f3; alu_zero = zr;
      imem_ready = (c > istall);
      dmem_ready = !(c >= mem_start && c < mem_start + dstall);
      #1;
      if (c == istall + 1) chk("fetch_irw", {imem_req, ir_write}, 2'b11);
      if (c == istall + 3) begin
        chk("exec_alusrc", ALUSrc, (op == T_I) || is_mem);
        chk("exec_aluop", ALUOp, (op == T_R || op == T_I) ? 2'b10 : (op == T_BR ? 2'b01 : 2'b00));
      end
      if (MemRead || MemWrite) begin
        mem_cycles++;
        chk("mem_rw", {MemRead, MemWrite}, (op == T_LD) ? 2'b10 : 2'b01);
        chk("mem_alu", {ALUSrc, ALUOp}, 3'b100);
      end
      if (retire) begin
        done = 1'b1;
        chk("latency", c, exp_q.pop_front());
        chk("ret_pc_write", pc_write, 1);
        chk("ret_pc_src", pc_src, (op == T_BR) ? exp_taken : 1'b0);
        chk("ret_regwrite", RegWrite, (op == T_R || op == T_I || op == T_LD));
        if (op == T_R || op == T_I || op == T_LD) chk("ret_memtoreg", MemtoReg, op != T_LD);
        if (is_mem) chk("mem_cycles", mem_cycles, dstall + 1);
      end
      @(negedge clk);
    end
    chk("retire_seen", done, 1);
    if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    if (done) cnt_model = cnt_model + 1'b1;
    #1;
    chk("retired_cnt", retired_cnt, cnt_model);
    chk("no_trap", trap, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    do_reset();

    run_instr(T_R, 3'b000, 1'b0, 0, 0);
    run_instr(T_LD, 3'b011, 1'b0, 0, 3);
    run_instr(T_ST, 3'b011, 1'b0, 0, 3);
    run_instr(T_BR, 3'b000, 1'b1, 0, 0);
    run_instr(T_BR, 3'b001, 1'b1, 0, 0);
    run_instr(T_BR, 3'b000, 1'b0, 0, 0);
    run_instr(T_BR, 3'b100, 1'b1, 0, 0);
    run_instr(T_I, 3'b000, 1'b0, 5, 0);

    for (int n = 0; n < 20; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0: op = T_R;
        1: op = T_I;
        2: op = T_LD;
        3: op = T_ST;
        default: op = T_BR;
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Illegal opcode: FETCH, DECODE, then TRAP with every strobe low.
    opcode = 7'h7F; imem_ready = 1'b1;
    #1 chk("ill_irw", ir_write, 1);
    @(negedge clk);
    #1 chk("ill_decode_trap", trap, 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("ill_strobes", strobes, 12'h000);
      chk("ill_trap", {trap, trap_cause}, 3'b101);
      chk("ill_state", state_dbg, ST_TRAP);
      @(negedge clk);
    end
    do_reset();
    run_instr(T_R, 3'b000, 1'b0, 0, 0);

    // imem watchdog: 16 waiting cycles, TRAP with cause 10 on the next.
    opcode = T_R; imem_ready = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      #1 chk("ifetch_wait", {imem_req, trap}, 2'b10);
      @(negedge clk);
    end
    #1;
    chk("imem_to_trap", {trap, trap_cause}, 3'b110);
    chk("imem_to_strobes", strobes, 12'h000);
    do_reset();
    run_instr(T_R, 3'b000, 1'b0, TIMEOUT - 1, 0);

    // dmem watchdog on a load.
    for (int c = 1; c <= 3 + TIMEOUT; c++) begin
      opcode = T_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
      if (c >= 4) chk("dmem_wait", {MemRead, trap}, 2'b10);
      @(negedge clk);
    end
    #1;
    chk("dmem_to_trap", {trap, trap_cause}, 3'b111);
    chk("dmem_to_strobes", strobes, 12'h000);
    do_reset();
    run_instr(T_LD, 3'b011, 1'b0, 0, TIMEOUT - 1);

    // Load aborted mid-MEM by reset: nothing retires and the counter clears.
    for (int c = 1; c <= 5; c++) begin
      opcode = T_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
      #1 chk("abort_no_retire", retire, 0);
      @(negedge clk);
    end
    do_reset();
    run_instr(T_ST, 3'b011, 1'b0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
